// File: rtl/precompute_pkg.sv
// Shared state encoding and error codes for the Montgomery-constant precompute sequencer.
package precompute_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t CHECK = 3'd1;
    localparam state_t ISSUE = 3'd2;
    localparam state_t WAIT  = 3'd3;
    localparam state_t CAPT  = 3'd4;
    localparam state_t FIN   = 3'd5;

    typedef logic [1:0] err_t;

    localparam err_t ERR_NONE    = 2'b00;
    localparam err_t ERR_BADM    = 2'b01;
    localparam err_t ERR_TIMEOUT = 2'b10;
    localparam err_t ERR_ABORT   = 2'b11;

endpackage

// File: rtl/precompute_scheduler_if.sv
// Control-side and step-unit-side bundles of the precompute sequencer.
interface precompute_ctrl_if
    import precompute_pkg::*;
#(
    parameter int unsigned WIDTH = 1024
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] M;
    logic [WIDTH-1:0] RM;
    logic [WIDTH-1:0] R2M;
    logic             busy;
    logic             done;
    err_t             err;

    modport master (output start, abort, M, input RM, R2M, busy, done, err);
    modport slave  (input start, abort, M, output RM, R2M, busy, done, err);
endinterface

interface precompute_step_if #(
    parameter int unsigned WIDTH = 1024
);
    logic             step_start;
    logic [WIDTH-1:0] step_operand;
    logic [WIDTH-1:0] step_M;
    logic             step_done;
    logic [WIDTH-1:0] step_result;

    modport master (output step_start, step_operand, step_M, input step_done, step_result);
    modport slave  (input step_start, step_operand, step_M, output step_done, step_result);
endinterface

// File: rtl/precompute_watchdog.sv
// Saturating cycle counter guarding the step handshake; expired_o is high in the
// TIMEOUT-th cycle after a load with the enable held.
module precompute_watchdog #(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] cnt_q, cnt_d;
    logic            expired_q;

    // Load arms the counter at 1 so the count equals the number of waiting cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = WD_W'(1);
        end else if (en_i && (cnt_q != WD_W'(TIMEOUT))) begin
            cnt_d = cnt_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= (cnt_d == WD_W'(TIMEOUT));
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/precompute_scheduler.sv
// Sequencer deriving RM = 2^WIDTH mod M and R2M = 2^(2*WIDTH) mod M by issuing
// 2*WIDTH modular doublings to an external step unit.
module precompute_scheduler
    import precompute_pkg::*;
#(
    parameter int unsigned WIDTH   = 1024,
    parameter int unsigned CNT_W   = 11,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    precompute_ctrl_if.slave  ctrl,
    precompute_step_if.master step
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] rm_q, rm_d;
    logic [WIDTH-1:0] r2m_q, r2m_d;
    err_t             err_q, err_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             step_start_q, step_start_d;
    logic             wd_expired;
    logic             bad_m;
    logic             last_step;

    assign bad_m     = (m_q == '0) || !m_q[0];
    assign last_step = (cnt_q == CNT_W'(2 * WIDTH - 1));

    precompute_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q == IDLE),
        .load_i    (state_q == ISSUE),
        .en_i      (state_q == WAIT),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort outranks every other event in the active states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (ctrl.start) state_d = CHECK;
            CHECK: state_d = (ctrl.abort || bad_m) ? FIN : ISSUE;
            ISSUE: state_d = ctrl.abort ? FIN : WAIT;
            WAIT: begin
                if (ctrl.abort)         state_d = FIN;
                else if (step.step_done) state_d = CAPT;
                else if (wd_expired)    state_d = FIN;
            end
            CAPT:  state_d = (ctrl.abort || last_step) ? FIN : ISSUE;
            FIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        x_d   = x_q;
        m_d   = m_q;
        rm_d  = rm_q;
        r2m_d = r2m_q;
        err_d = err_q;
        case (state_q)
            IDLE: begin
                if (ctrl.start) begin
                    m_d   = ctrl.M;
                    err_d = ERR_NONE;
                end
            end
            CHECK: begin
                if (ctrl.abort) begin
                    err_d = ERR_ABORT;
                end else if (bad_m) begin
                    err_d = ERR_BADM;
                    rm_d  = '0;
                    r2m_d = '0;
                end else begin
                    // Seeding with 0 for M==1 keeps x < M from the first step.
                    x_d   = (m_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                    cnt_d = '0;
                end
            end
            ISSUE: if (ctrl.abort) err_d = ERR_ABORT;
            WAIT: begin
                if (ctrl.abort)          err_d = ERR_ABORT;
                else if (step.step_done) x_d   = step.step_result;
                else if (wd_expired)     err_d = ERR_TIMEOUT;
            end
            CAPT: begin
                if (ctrl.abort) begin
                    err_d = ERR_ABORT;
                end else begin
                    if (cnt_q == CNT_W'(WIDTH - 1)) rm_d = x_q;
                    if (last_step) r2m_d = x_q;
                    else           cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
        step_start_d = (state_d == ISSUE);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == FIN) && (err_d == ERR_NONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            x_q          <= '0;
            m_q          <= '0;
            rm_q         <= '0;
            r2m_q        <= '0;
            err_q        <= ERR_NONE;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            step_start_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            m_q          <= m_d;
            rm_q         <= rm_d;
            r2m_q        <= r2m_d;
            err_q        <= err_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            step_start_q <= step_start_d;
        end
    end

    assign ctrl.RM           = rm_q;
    assign ctrl.R2M          = r2m_q;
    assign ctrl.err          = err_q;
    assign ctrl.done         = done_q;
    assign ctrl.busy         = busy_q;
    assign step.step_start   = step_start_q;
    assign step.step_operand = x_q;
    assign step.step_M       = m_q;

endmodule

// File: tb/tb_precompute_scheduler.sv
// Directed bench for precompute_scheduler at WIDTH=8 with a behavioural doubling step unit.
module tb_precompute_scheduler;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned TIMEOUT = 32;

    logic clk;
    logic reset;

    precompute_ctrl_if #(.WIDTH(WIDTH)) ctrl ();
    precompute_step_if #(.WIDTH(WIDTH)) step ();

    precompute_scheduler #(
        .WIDTH   (WIDTH),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (ctrl),
        .step  (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Step-unit model configuration, written by the main sequence only.
    int run_id   = 0;
    int ls       = 3;
    int rand_ls  = 0;
    int stall_at = 0;
    int abort_at = 0;

    logic mdl_done  = 1'b0;
    logic mdl_abort = 1'b0;
    logic spur_done = 1'b0;

    assign step.step_done = mdl_done | spur_done;
    assign ctrl.abort     = mdl_abort;

    // Behavioural step unit: answers each request with 2x mod M after Ls cycles.
    initial begin
        int            cur_id;
        int            req_n;
        int            cur_ls;
        logic [WIDTH-1:0] op;
        logic [WIDTH:0]   prod;
        logic [WIDTH:0]   modl;
        cur_id = 0;
        req_n  = 0;
        step.step_result = '0;
        forever begin
            @(posedge clk); #1;
            if (cur_id != run_id) begin
                cur_id = run_id;
                req_n  = 0;
            end
            if (step.step_start === 1'b1) begin
                req_n++;
                op   = step.step_operand;
                prod = {op, 1'b0};
                modl = {1'b0, step.step_M};
                if (req_n != stall_at) begin
                    cur_ls = (rand_ls != 0) ? int'($urandom_range(1, 10)) : ls;
                    repeat (cur_ls) begin @(posedge clk); #1; end
                    step.step_result = WIDTH'(prod % modl);
                    mdl_done  = 1'b1;
                    mdl_abort = (req_n == abort_at);
                    @(posedge clk); #1;
                    mdl_done  = 1'b0;
                    mdl_abort = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Per-run observations, counted in cycles with the start cycle as cycle 1.
    int   lat, done_lat, n_done, n_ss, n_busy, err_lat, last_ss;
    logic ended;
    logic [1:0] err_at2;

    task automatic run(input logic [WIDTH-1:0] m, input int glitch);
        @(negedge clk);
        ctrl.M     = m;
        ctrl.start = 1'b1;
        run_id++;
        lat = 1; done_lat = 0; n_done = 0; n_ss = 0; n_busy = 0;
        err_lat = 0; last_ss = 0; ended = 1'b0; err_at2 = 2'bxx;
        for (int i = 0; i < 3000 && !ended; i++) begin
            @(negedge clk);
            lat++;
            ctrl.start = (lat == glitch);
            if (lat == 2) err_at2 = ctrl.err;
            if (step.step_start) begin n_ss++; last_ss = lat; end
            if (ctrl.done) begin n_done++; if (done_lat == 0) done_lat = lat; end
            if (ctrl.err != 2'b00 && err_lat == 0) err_lat = lat;
            if (ctrl.busy) n_busy++;
            else           ended = 1'b1;
        end
        check("run_ended", 32'(ended), 32'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] rm_m;
        ctrl.start = 1'b0;
        ctrl.M     = '0;
        reset      = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(ctrl.busy), 32'd0);
        check("rst_done", 32'(ctrl.done), 32'd0);
        check("rst_err", 32'(ctrl.err), 32'd0);
        check("rst_rm", 32'(ctrl.RM), 32'd0);
        check("rst_r2m", 32'(ctrl.R2M), 32'd0);
        check("rst_step_start", 32'(step.step_start), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Scenario 1: M=0xB3 nominal run
        run(8'hB3, 0);
        check("s1_rm", 32'(ctrl.RM), 32'h4D);
        check("s1_r2m", 32'(ctrl.R2M), 32'h16);
        check("s1_err", 32'(ctrl.err), 32'd0);
        check("s1_latency", 32'(done_lat), 32'd83);
        check("s1_done_count", 32'(n_done), 32'd1);
        check("s1_step_pulses", 32'(n_ss), 32'd16);
        check("s1_busy_cycles", 32'(n_busy), 32'd82);

        // Scenario 2b: even modulus rejected, constants forced to zero
        run(8'hB2, 0);
        check("s2b_err", 32'(ctrl.err), 32'h1);
        check("s2b_step_pulses", 32'(n_ss), 32'd0);
        check("s2b_done_count", 32'(n_done), 32'd0);
        check("s2b_busy_cycles", 32'(n_busy), 32'd2);
        check("s2b_rm", 32'(ctrl.RM), 32'd0);
        check("s2b_r2m", 32'(ctrl.R2M), 32'd0);

        // Scenario 2a: M=1 gives zero constants with normal completion
        run(8'h01, 0);
        check("s2a_rm", 32'(ctrl.RM), 32'd0);
        check("s2a_r2m", 32'(ctrl.R2M), 32'd0);
        check("s2a_err", 32'(ctrl.err), 32'd0);
        check("s2a_done_count", 32'(n_done), 32'd1);

        // Scenario 3: step unit never answers the 5th request
        stall_at = 5;
        run(8'hB3, 0);
        stall_at = 0;
        check("s3_err", 32'(ctrl.err), 32'h2);
        check("s3_done_count", 32'(n_done), 32'd0);
        check("s3_step_pulses", 32'(n_ss), 32'd5);
        check("s3_timeout_gap", 32'(err_lat - last_ss), 32'(TIMEOUT + 1));
        check("s3_busy_cycles", 32'(n_busy), 32'd55);

        // Scenario 4: abort coincides with the 9th step_done
        abort_at = 9;
        run(8'hB3, 0);
        abort_at = 0;
        check("s4_err", 32'(ctrl.err), 32'h3);
        check("s4_done_count", 32'(n_done), 32'd0);
        check("s4_step_pulses", 32'(n_ss), 32'd9);
        check("s4_rm", 32'(ctrl.RM), 32'h4D);
        check("s4_r2m", 32'(ctrl.R2M), 32'd0);

        // Scenario 5: stray step_done in IDLE, start re-pulsed during WAIT
        @(negedge clk); spur_done = 1'b1;
        @(negedge clk); spur_done = 1'b0;
        @(negedge clk);
        check("s5_idle_busy", 32'(ctrl.busy), 32'd0);
        check("s5_idle_err", 32'(ctrl.err), 32'h3);
        run(8'hB3, 5);
        check("s5_err_cleared", 32'(err_at2), 32'd0);
        check("s5_rm", 32'(ctrl.RM), 32'h4D);
        check("s5_r2m", 32'(ctrl.R2M), 32'h16);
        check("s5_latency", 32'(done_lat), 32'd83);
        check("s5_step_pulses", 32'(n_ss), 32'd16);

        // Scenario 6: asynchronous reset while waiting on the step unit
        @(negedge clk);
        ctrl.M = 8'hB3; ctrl.start = 1'b1; run_id++;
        @(negedge clk); ctrl.start = 1'b0;
        repeat (3) @(negedge clk);
        check("s6_pre_busy", 32'(ctrl.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("s6_busy", 32'(ctrl.busy), 32'd0);
        check("s6_err", 32'(ctrl.err), 32'd0);
        check("s6_rm", 32'(ctrl.RM), 32'd0);
        check("s6_r2m", 32'(ctrl.R2M), 32'd0);
        check("s6_done", 32'(ctrl.done), 32'd0);
        check("s6_step_start", 32'(step.step_start), 32'd0);
        check("s6_operand", 32'(step.step_operand), 32'd0);
        @(negedge clk); reset = 1'b0;
        repeat (20) @(negedge clk);
        run(8'hB3, 0);
        check("s6_rm_after", 32'(ctrl.RM), 32'h4D);
        check("s6_r2m_after", 32'(ctrl.R2M), 32'h16);
        check("s6_latency", 32'(done_lat), 32'd83);

        // Random odd moduli with random step latency against 2^8 / 2^16 mod M
        rand_ls = 1;
        for (int k = 0; k < 6; k++) begin
            rm_m = WIDTH'($urandom_range(1, 255)) | WIDTH'(1);
            run(rm_m, 0);
            check("rand_rm", 32'(ctrl.RM), 32'd256 % 32'(rm_m));
            check("rand_r2m", 32'(ctrl.R2M), 32'd65536 % 32'(rm_m));
            check("rand_err", 32'(ctrl.err), 32'd0);
        end
        rand_ls = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
